// File: rtl/stride_counter.sv
// stride_counter: registered counter that starts at INIT and moves by STEP
// on each enabled cycle. It counts up or down, and on overflow it either
// wraps or saturates. It also has a synchronous clear and a parallel load.
// With the default parameters it produces the odd sequence 1, 3, 5, ...
module stride_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 2,
    parameter int unsigned INIT  = 1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    input  logic             en_i,
    input  logic             dir_i,      // 0 = up, 1 = down
    input  logic             sat_i,      // 0 = wrap, 1 = saturate
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             wrap_o,
    output logic             sat_o
);

    // Largest value a WIDTH-bit counter can hold. It is computed in 33 bits
    // so that WIDTH=32 is handled.
    localparam logic [32:0] C_MAX = (33'd1 << WIDTH) - 33'd1;

    // Reject illegal parameter combinations at elaboration.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("stride_counter: WIDTH must be in 2..32");
    end
    if (STEP < 1 || 33'(STEP) > C_MAX) begin : g_bad_step
        $error("stride_counter: STEP must be in 1..2^WIDTH-1");
    end
    if (33'(INIT) > C_MAX) begin : g_bad_init
        $error("stride_counter: INIT must be in 0..2^WIDTH-1");
    end

    localparam logic [WIDTH:0]   C_STEP = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] C_INIT = WIDTH'(INIT);

    logic [WIDTH-1:0] r_cnt;
    logic             r_wrap;
    logic             r_sat;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic             w_ovf;
    logic             w_unf;
    logic             w_blocked;
    logic [WIDTH-1:0] w_next;

    // The step is computed one bit wider than the counter. The extra MSB is
    // the carry out for up steps and the borrow for down steps, so landing
    // exactly on a bound does not count as an overflow.
    assign w_sum     = {1'b0, r_cnt} + C_STEP;
    assign w_diff    = {1'b0, r_cnt} - C_STEP;
    assign w_ovf     = w_sum[WIDTH];
    assign w_unf     = w_diff[WIDTH];
    assign w_blocked = dir_i ? w_unf : w_ovf;
    // The low bits are already the value modulo 2^WIDTH, which is what the
    // wrap mode needs.
    assign w_next    = dir_i ? w_diff[WIDTH-1:0] : w_sum[WIDTH-1:0];

    // Counter state, applied in priority order: clear, load, step, hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= C_INIT;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (clr_i) begin
            r_cnt  <= C_INIT;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (load_i) begin
            r_cnt  <= load_val_i;
            r_wrap <= 1'b0;
            r_sat  <= 1'b0;
        end else if (en_i) begin
            if (!w_blocked) begin
                r_cnt  <= w_next;
                r_wrap <= 1'b0;
                r_sat  <= 1'b0;
            end else if (!sat_i) begin
                r_cnt  <= w_next;
                r_wrap <= 1'b1;
                r_sat  <= 1'b0;
            end else begin
                // A blocked step in saturate mode: hold the count and flag it.
                r_wrap <= 1'b0;
                r_sat  <= 1'b1;
            end
        end else begin
            // Idle: the wrap pulse ends here, but the saturation flag keeps
            // its level.
            r_wrap <= 1'b0;
        end
    end

    assign cnt_o  = r_cnt;
    assign wrap_o = r_wrap;
    assign sat_o  = r_sat;

endmodule

// File: tb/tb_stride_counter.sv
// Scoreboard bench for stride_counter. Stimulus drives inputs 1 ns after
// each falling edge and queues the expected outputs. A monitor pops one
// entry per falling edge and compares it against the DUT. A second
// instance (WIDTH=4, STEP=3, INIT=0) has its own queue and monitor.
module tb_stride_counter;

    typedef struct {
        logic [7:0] cnt;
        logic       wrap;
        logic       sat;
        string      name;
    } exp_t;

    exp_t q_main[$];
    exp_t q_alt[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 0, dir = 0, sat = 0, clr = 0, load = 0;
    logic [7:0] lv = '0;
    logic [7:0] cnt;
    logic       wrap, sato;

    logic       a_en = 0, a_dir = 0, a_sat = 0;
    logic [3:0] a_cnt;
    logic       a_wrap, a_sato;

    always #5 clk = ~clk;

    stride_counter dut (
        .clk(clk), .reset(reset), .en_i(en), .dir_i(dir), .sat_i(sat),
        .clr_i(clr), .load_i(load), .load_val_i(lv),
        .cnt_o(cnt), .wrap_o(wrap), .sat_o(sato)
    );

    stride_counter #(.WIDTH(4), .STEP(3), .INIT(0)) dut_alt (
        .clk(clk), .reset(reset), .en_i(a_en), .dir_i(a_dir), .sat_i(a_sat),
        .clr_i(1'b0), .load_i(1'b0), .load_val_i(4'd0),
        .cnt_o(a_cnt), .wrap_o(a_wrap), .sat_o(a_sato)
    );

    task automatic chk(input string nm, input logic [7:0] gc, input logic gw, input logic gs,
                       input logic [7:0] ec, input logic ew, input logic es);
        n_tests++;
        if (gc !== ec || gw !== ew || gs !== es) begin
            n_fail++;
            $display("FAIL %s: got cnt=%0d wrap=%0b sat=%0b, want cnt=%0d wrap=%0b sat=%0b",
                     nm, gc, gw, gs, ec, ew, es);
        end
    endtask

    // Main-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                chk(e.name, cnt, wrap, sato, e.cnt, e.wrap, e.sat);
            end
        end
    end

    // Alternate-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_alt.size() > 0) begin
                e = q_alt.pop_front();
                chk(e.name, {4'd0, a_cnt}, a_wrap, a_sato, e.cnt, e.wrap, e.sat);
            end
        end
    end

    task automatic cyc(input logic i_en, input logic i_dir, input logic i_sat,
                       input logic i_clr, input logic i_load, input logic [7:0] i_lv,
                       input logic [7:0] ec, input logic ew, input logic es, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        en = i_en; dir = i_dir; sat = i_sat; clr = i_clr; load = i_load; lv = i_lv;
        e.cnt = ec; e.wrap = ew; e.sat = es; e.name = nm;
        q_main.push_back(e);
    endtask

    task automatic acyc(input logic i_en, input logic i_dir, input logic i_sat,
                        input logic [7:0] ec, input logic ew, input logic es, input string nm);
        exp_t e;
        @(negedge clk);
        #1;
        a_en = i_en; a_dir = i_dir; a_sat = i_sat;
        e.cnt = ec; e.wrap = ew; e.sat = es; e.name = nm;
        q_alt.push_back(e);
    endtask

    initial begin
        // Reset held low for 3 cycles; outputs sit at INIT.
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, 1, 0, 0, "reset_state");
        @(negedge clk);
        #1;
        reset = 1'b1;
        en = 0;

        // 1. Default odd sequence.
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, "odd_init");
        cyc(1, 0, 0, 0, 0, 0, 3, 0, 0, "odd_3");
        cyc(1, 0, 0, 0, 0, 0, 5, 0, 0, "odd_5");
        cyc(1, 0, 0, 0, 0, 0, 7, 0, 0, "odd_7");

        // 2. Wrap: from INIT, 127 steps reach 255, and step 128 wraps to 1.
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, "wrap_clr");
        for (int k = 1; k <= 127; k++)
            cyc(1, 0, 0, 0, 0, 0, 8'(1 + 2 * k), 0, 0, "wrap_climb");
        cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, "wrap_pulse");
        cyc(1, 0, 0, 0, 0, 0, 3, 0, 0, "wrap_after");

        // 3. Saturate at the top, then step back down.
        cyc(0, 0, 1, 0, 1, 253, 253, 0, 0, "sat_load");
        cyc(1, 0, 1, 0, 0, 0, 255, 0, 0, "sat_exact_reach");
        cyc(1, 0, 1, 0, 0, 0, 255, 0, 1, "sat_blocked");
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 0, 255, 0, 1, "sat_hold");
        cyc(0, 0, 1, 0, 0, 0, 255, 0, 1, "sat_idle_hold");
        cyc(1, 1, 1, 0, 0, 0, 253, 0, 0, "sat_dir_release");

        // 4. Down count and underflow, in wrap mode and then saturate mode.
        cyc(0, 1, 0, 0, 1, 4, 4, 0, 0, "down_load");
        cyc(1, 1, 0, 0, 0, 0, 2, 0, 0, "down_2");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, "down_0");
        cyc(1, 1, 0, 0, 0, 0, 254, 1, 0, "down_wrap");
        cyc(0, 1, 1, 0, 1, 4, 4, 0, 0, "down_load2");
        cyc(1, 1, 1, 0, 0, 0, 2, 0, 0, "down_sat_2");
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 0, "down_sat_0");
        cyc(1, 1, 1, 0, 0, 0, 0, 0, 1, "down_sat_blocked");
        cyc(0, 1, 1, 0, 1, 9, 9, 0, 0, "load_clears_sat");

        // 5. Priority of clear, load, and enable.
        cyc(1, 0, 0, 1, 1, 100, 1, 0, 0, "prio_clr");
        cyc(1, 0, 0, 0, 1, 100, 100, 0, 0, "prio_load");
        cyc(0, 0, 0, 0, 0, 0, 100, 0, 0, "prio_hold");

        // 6a. Reset asserted between edges takes effect immediately.
        cyc(0, 0, 0, 1, 0, 0, 1, 0, 0, "ar_clr");
        cyc(1, 0, 0, 0, 0, 0, 3, 0, 0, "ar_3");
        cyc(1, 0, 0, 0, 0, 0, 5, 0, 0, "ar_5");
        @(negedge clk);
        #1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        en = 0;
        #1;
        chk("async_reset", cnt, wrap, sato, 1, 0, 0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, "after_reset");

        // 6b. Alternate parameters: WIDTH=4, STEP=3, INIT=0.
        acyc(0, 0, 0, 0, 0, 0, "alt_init");
        acyc(1, 0, 0, 3, 0, 0, "alt_3");
        acyc(1, 0, 0, 6, 0, 0, "alt_6");
        acyc(1, 0, 0, 9, 0, 0, "alt_9");
        acyc(1, 0, 0, 12, 0, 0, "alt_12");
        acyc(1, 0, 0, 15, 0, 0, "alt_15");
        acyc(1, 0, 0, 2, 1, 0, "alt_wrap");
        acyc(1, 0, 0, 5, 0, 0, "alt_5");
        acyc(1, 0, 0, 8, 0, 0, "alt_8");
        acyc(1, 0, 0, 11, 0, 0, "alt_11");
        acyc(1, 0, 0, 14, 0, 0, "alt_14");
        acyc(1, 0, 1, 14, 0, 1, "alt_sat");
        acyc(1, 1, 0, 11, 0, 0, "alt_down_11");
        acyc(1, 1, 0, 8, 0, 0, "alt_down_8");
        acyc(1, 1, 0, 5, 0, 0, "alt_down_5");
        acyc(1, 1, 0, 2, 0, 0, "alt_down_2");
        acyc(1, 1, 0, 15, 1, 0, "alt_down_wrap");
        acyc(0, 1, 0, 15, 0, 0, "alt_idle");

        @(negedge clk);
        @(negedge clk);
        #1;
        n_tests++;
        if (q_main.size() != 0 || q_alt.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q_main.size(), q_alt.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
